// File: rtl/pwm_burst_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_burst_multi                                                      |
// | CH independent PWM burst channels: T periods of P cycles with H high |
// | (T=0 runs until stopped); P/H reload glitch-free at period ends.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module pwm_burst_multi #(
  parameter int CH = 4,
  parameter int CW = 32,
  parameter int TW = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [CH-1:0]    i_start,
  input  logic [CH-1:0]    i_stop,
  input  logic [CH*CW-1:0] i_period,
  input  logic [CH*CW-1:0] i_high,
  input  logic [CH*TW-1:0] i_times,
  output logic [CH-1:0]    o_pwm,
  output logic [CH-1:0]    o_busy,
  output logic [CH-1:0]    o_done
);

  localparam logic [CW-1:0] c_p_one = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] c_t_one = {{(TW-1){1'b0}}, 1'b1};

  for (genvar n = 0; n < CH; n++) begin : g_ch
    logic [CW-1:0] w_period_in;
    logic [CW-1:0] w_high_in;
    logic [TW-1:0] w_times_in;
    logic          w_start_pls;
    logic          w_wrap;
    logic          w_last;

    logic          r_start_q;
    logic          r_start_vld;
    logic          r_busy;
    logic          r_pwm;
    logic          r_done;
    logic [CW-1:0] r_pcnt;
    logic [CW-1:0] r_p;
    logic [CW-1:0] r_h;
    logic [TW-1:0] r_tcnt;
    logic [TW-1:0] r_t;

    assign w_period_in = i_period[n*CW +: CW];
    assign w_high_in   = i_high[n*CW +: CW];
    assign w_times_in  = i_times[n*TW +: TW];

    // r_start_vld stops a start level held across reset release from
    // looking like an edge: a rising edge needs a genuinely sampled 0.
    assign w_start_pls = i_start[n] & ~r_start_q & r_start_vld;
    assign w_wrap      = (|r_p) && (r_pcnt == r_p - c_p_one);
    assign w_last      = (|r_t) && (r_tcnt == r_t - c_t_one);

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_start_q   <= 1'b0;
        r_start_vld <= 1'b0;
        r_busy      <= 1'b0;
        r_pwm       <= 1'b0;
        r_done      <= 1'b0;
        r_pcnt      <= '0;
        r_p         <= '0;
        r_h         <= '0;
        r_tcnt      <= '0;
        r_t         <= '0;
      end else begin
        r_start_q   <= i_start[n];
        r_start_vld <= 1'b1;
        r_done      <= 1'b0;
        r_pwm       <= r_busy && (r_pcnt < r_h);

        if (i_stop[n]) begin
          r_busy <= 1'b0;
          r_pcnt <= '0;
          r_tcnt <= '0;
        end else if (w_start_pls && (|w_period_in)) begin
          r_p    <= w_period_in;
          r_h    <= w_high_in;
          r_t    <= w_times_in;
          r_pcnt <= '0;
          r_tcnt <= '0;
          r_busy <= 1'b1;
        end else if (r_busy) begin
          if (w_wrap) begin
            r_pcnt <= '0;
            // A zero period on the inputs keeps the running period.
            if (|w_period_in) begin
              r_p <= w_period_in;
            end
            r_h <= w_high_in;
            if (|r_t) begin
              if (w_last) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_tcnt <= '0;
              end else begin
                r_tcnt <= r_tcnt + c_t_one;
              end
            end
          end else begin
            r_pcnt <= r_pcnt + c_p_one;
          end
        end
      end
    end

    assign o_pwm[n]  = r_pwm;
    assign o_busy[n] = r_busy;
    assign o_done[n] = r_done;
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_burst_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pwm_burst_multi                                                   |
// | Directed vector table plus hand-written multi-cycle sequences.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_pwm_burst_multi;
  localparam int CH = 4;
  localparam int CW = 32;
  localparam int TW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]    start;
  logic [CH-1:0]    stop;
  logic [CH*CW-1:0] period;
  logic [CH*CW-1:0] high;
  logic [CH*TW-1:0] times;
  logic [CH-1:0]    pwm;
  logic [CH-1:0]    busy;
  logic [CH-1:0]    done;

  int n_vec = 0;
  int n_err = 0;

  pwm_burst_multi #(.CH(CH), .CW(CW), .TW(TW)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_stop   (stop),
    .i_period (period),
    .i_high   (high),
    .i_times  (times),
    .o_pwm    (pwm),
    .o_busy   (busy),
    .o_done   (done)
  );

  always #10 clk = ~clk;

  typedef struct {
    int ch;
    int p;
    int h;
    int t;
    bit acc;
    int busy_n;
    int high_n;
    int done_n;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input int p, input int h, input int t);
    period[ch*CW +: CW] = CW'(p);
    high[ch*CW +: CW]   = CW'(h);
    times[ch*TW +: TW]  = TW'(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, hc, dc, bad, len, h1, h2;
    logic [CH-1:0] eb, ep, ed;

    tbl[0] = '{ch:0, p:5, h:2,  t:3, acc:1, busy_n:15, high_n:6,  done_n:1};
    tbl[1] = '{ch:3, p:6, h:0,  t:2, acc:1, busy_n:12, high_n:0,  done_n:1};
    tbl[2] = '{ch:2, p:8, h:12, t:2, acc:1, busy_n:16, high_n:16, done_n:1};
    tbl[3] = '{ch:1, p:1, h:1,  t:4, acc:1, busy_n:4,  high_n:4,  done_n:1};
    tbl[4] = '{ch:0, p:0, h:2,  t:3, acc:0, busy_n:0,  high_n:0,  done_n:0};
    tbl[5] = '{ch:3, p:3, h:1,  t:1, acc:1, busy_n:3,  high_n:1,  done_n:1};

    rst = 1'b1; start = '0; stop = '0; period = '0; high = '0; times = '0;
    tick; tick; tick;
    check("reset_outputs", {pwm, busy, done}, 0);
    rst = 1'b0;
    tick;

    // Table: expected waveform derived from start edge k, sample j after edge k+j.
    for (int i = 0; i < 6; i++) begin
      set_ch(tbl[i].ch, tbl[i].p, tbl[i].h, tbl[i].t);
      start[tbl[i].ch] = 1'b1;
      tick;
      start[tbl[i].ch] = 1'b0;
      bc = 0; hc = 0; dc = 0; bad = 0;
      len = tbl[i].t * tbl[i].p + 4;
      for (int j = 0; j < len; j++) begin
        eb = '0; ep = '0; ed = '0;
        if (tbl[i].acc) begin
          eb[tbl[i].ch] = (j < tbl[i].t * tbl[i].p);
          ed[tbl[i].ch] = (j == tbl[i].t * tbl[i].p);
          if (j >= 1 && (j - 1) < tbl[i].t * tbl[i].p)
            ep[tbl[i].ch] = (((j - 1) % tbl[i].p) < tbl[i].h);
        end
        if (busy !== eb || pwm !== ep || done !== ed) bad++;
        bc += int'(busy[tbl[i].ch]);
        hc += int'(pwm[tbl[i].ch]);
        dc += int'(done[tbl[i].ch]);
        tick;
      end
      check($sformatf("vec%0d_waveform", i), bad, 0);
      check($sformatf("vec%0d_busy_cycles", i), bc, tbl[i].busy_n);
      check($sformatf("vec%0d_pwm_high", i), hc, tbl[i].high_n);
      check($sformatf("vec%0d_done", i), dc, tbl[i].done_n);
    end

    // Continuous run on ch1, then stop.
    set_ch(1, 4, 1, 0);
    start[1] = 1'b1;
    tick;
    start[1] = 1'b0;
    bad = 0; dc = 0;
    for (int j = 0; j < 40; j++) begin
      if (busy[1] !== 1'b1 || pwm[1] !== (j >= 1 && ((j - 1) % 4) == 0)) bad++;
      dc += int'(done[1]);
      if (j < 39) tick;
    end
    check("cont_pattern", bad, 0);
    stop[1] = 1'b1;
    tick;
    check("stop_busy", busy[1], 0);
    dc += int'(done[1]);
    stop[1] = 1'b0;
    tick;
    check("stop_pwm", pwm[1], 0);
    dc += int'(done[1]);
    check("stop_no_done", dc, 0);

    // High-time change mid-period on ch2 lands at the next period.
    set_ch(2, 10, 3, 0);
    start[2] = 1'b1;
    tick;
    start[2] = 1'b0;
    h1 = 0; h2 = 0;
    for (int j = 0; j <= 20; j++) begin
      if (j >= 1 && j <= 10) h1 += int'(pwm[2]);
      if (j >= 11) h2 += int'(pwm[2]);
      if (j == 4) high[2*CW +: CW] = 32'd7;
      tick;
    end
    check("reload_cur_period", h1, 3);
    check("reload_next_period", h2, 7);
    stop[2] = 1'b1;
    tick;
    stop[2] = 1'b0;
    tick;

    // Restart mid-burst on ch0 with a new period.
    set_ch(0, 5, 2, 3);
    start[0] = 1'b1;
    tick;
    start[0] = 1'b0;
    dc = 0;
    for (int j = 0; j < 7; j++) begin
      dc += int'(done[0]);
      tick;
    end
    set_ch(0, 6, 2, 3);
    start[0] = 1'b1;
    tick;
    start[0] = 1'b0;
    bc = 0; hc = 0;
    for (int j = 0; j < 25; j++) begin
      bc += int'(busy[0]);
      hc += int'(pwm[0]);
      dc += int'(done[0]);
      tick;
    end
    check("restart_busy", bc, 18);
    check("restart_pwm_high", hc, 6);
    check("restart_done", dc, 1);

    // Simultaneous start/stop, then a held-high start.
    set_ch(1, 4, 1, 0);
    start[1] = 1'b1;
    stop[1] = 1'b1;
    tick;
    check("start_stop_idle", busy[1], 0);
    stop[1] = 1'b0;
    bc = 0;
    for (int j = 0; j < 5; j++) begin
      tick;
      bc += int'(busy[1]);
    end
    check("held_start_no_trigger", bc, 0);
    start[1] = 1'b0;
    tick;

    // Asynchronous reset mid-burst on all channels.
    for (int c = 0; c < CH; c++) set_ch(c, 5, 5, 0);
    start = '1;
    tick; tick; tick;
    check("all_busy", busy, 4'hf);
    check("all_pwm", pwm, 4'hf);
    @(posedge clk);
    #5 rst = 1'b1;
    #1 check("async_reset", {pwm, busy, done}, 0);
    #4 rst = 1'b0;
    bc = 0;
    for (int j = 0; j < 5; j++) begin
      tick;
      bc += int'(busy != 0);
    end
    check("post_reset_idle", bc, 0);
    start = '0;
    tick;
    start = '1;
    tick;
    check("post_reset_restart", busy, 4'hf);
    start = '0;
    stop = '1;
    tick;
    stop = '0;
    tick;
    check("final_idle", {pwm, busy, done}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
